// File: rtl/divide_if.sv
// Handshake and operand/result bundle for the divide block.
// The master drives the request and the slave returns results.
interface divide_if #(
  parameter int unsigned N = 8
) ();
  logic           start;
  logic [2*N-1:0] c;
  logic [N-1:0]   b;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;
  logic           div_zero;

  modport master (
    output start, c, b,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, c, b,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/divide.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per cycle, MSB first, with divide-by-zero detection.
module divide #(
  parameter int unsigned N = 8
) (
  input logic     clk,
  input logic     rst_n,
  divide_if.slave bus
);

  localparam int unsigned CW = $clog2(2 * N);
  localparam logic [CW-1:0] LastCnt = CW'(2 * N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] dvd;
  logic [2*N-1:0] quo;
  logic [N:0]     rem;
  logic [N-1:0]   dvs;
  logic           zero_pend;

  logic [N:0]     shifted;
  logic [N:0]     diff;
  logic           fits;
  logic [N:0]     rem_nxt;
  logic [2*N-1:0] quo_nxt;

  // One restoring step: bring in the next dividend bit, keep the difference if it fits.
  always_comb begin
    shifted = {rem[N-1:0], dvd[2*N-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = (shifted >= {1'b0, dvs});
    rem_nxt = fits ? diff : shifted;
    quo_nxt = {quo[2*N-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      cnt          <= '0;
      dvd          <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      zero_pend    <= 1'b0;
      bus.q        <= '0;
      bus.r        <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        StIdle, StDone: begin
          if (bus.start) begin
            dvd          <= bus.c;
            dvs          <= bus.b;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            zero_pend    <= (bus.b == '0);
            bus.busy     <= (bus.b != '0);
            bus.div_zero <= 1'b0;
            state        <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          if (zero_pend) begin
            // Divide by zero finishes on the first edge without iterating.
            zero_pend    <= 1'b0;
            bus.q        <= '1;
            bus.r        <= dvd[N-1:0];
            bus.div_zero <= 1'b1;
            bus.done     <= 1'b1;
            state        <= StDone;
          end else begin
            dvd <= dvd << 1;
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              bus.q    <= quo_nxt;
              bus.r    <= rem_nxt[N-1:0];
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= StDone;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 The block SHALL have one parameter: N, default 8, divisor/remainder width; dividend/quotient width is 2N.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to begin a division; sampled on rising clk.
REQ-006 Port c  input  2N  dividend (product-width operand).
REQ-007 Port b  input  N  divisor.
REQ-008 Port q  output  2N  quotient, registered.
REQ-009 Port r  output  N  remainder, registered.
REQ-010 Port busy  output  1  high while iterating; start ignored.
REQ-011 Port done  output  1  one-cycle pulse when q/r/div_zero are valid.
REQ-012 Port div_zero  output  1  high with done when b was zero.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at edge E SHALL latch c and b into internal registers, clear the iteration counter and partial remainder, and enter RUN (b!=0) or DONE-with-error (b==0).
REQ-015 In RUN, start SHALL be ignored; changes on c and b SHALL have no effect until the next accepted start.
REQ-016 RUN SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first, using an (N+1)-bit partial remainder: shift in the next dividend bit, subtract the divisor if the result is non-negative, and set the quotient bit accordingly.
REQ-017 RUN SHALL last exactly 2N edges (E+1..E+2N); at edge E+2N, q, r and done SHALL update, busy SHALL fall, and the state SHALL become DONE.
REQ-018 Latency SHALL be 2N cycles from the start edge to done high (16 for N=8).
REQ-019 done SHALL be high for exactly one cycle; DONE SHALL return to IDLE at the next edge unless start=1, which is accepted per REQ-014.
REQ-020 busy SHALL be high from edge E+1 through edge E+2N and low otherwise.
REQ-021 Results SHALL satisfy c == q*b + r with r < b for every b != 0, and SHALL not overflow for any 2N-bit c.
REQ-022 If b==0 at start, at edge E+1 the block SHALL set q = all ones, r = c[N-1:0], div_zero=1 and done=1, with busy never asserted.
REQ-023 div_zero SHALL be cleared on the next accepted start and otherwise held with q and r.
REQ-024 q, r and div_zero SHALL hold their last values until the next completion or reset.
REQ-025 start and reset asserted together SHALL give reset priority.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, q=0, r=0, busy=0, done=0, div_zero=0, and clear the counter and internal registers, including mid-RUN.
REQ-027 After rst_n rises, no operation SHALL resume; a new start is required.

Verification
REQ-028 c=15, b=5, start one cycle -> done exactly 16 cycles later, q=3, r=0, div_zero=0.
REQ-029 c=65025, b=255 -> q=255, r=0; c=510, b=2 -> q=255, r=0; c=1000, b=7 -> q=142, r=6.
REQ-030 c=65535, b=1 -> q=65535, r=0; c=100, b=200 -> q=0, r=100.
REQ-031 b=0, c=0x1234 -> one cycle after start: done=1, div_zero=1, q=0xFFFF, r=0x34, busy=0 throughout.
REQ-032 start c=20, b=2, then start c=9, b=3 at cycle 5 with changed inputs -> second start ignored, q=10, r=0 at cycle 16.
REQ-033 rst_n low at cycle 8 of a RUN -> all outputs 0 immediately; after release, no done appears until a new start; c=50, b=4 then gives q=12, r=2.
